// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and APB FSM state type for the timer interrupt stage
package timer_pkg;

  localparam logic [7:0] ADDR_TIER  = 8'h10;
  localparam logic [7:0] ADDR_TISR  = 8'h11;
  localparam logic [7:0] ADDR_OVCNT = 8'h12;
  localparam logic [7:0] ADDR_IPEND = 8'h13;

  localparam int OVF_BIT = 0;
  localparam int UDF_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/timer_apb_if.sv
// rtl/timer_apb_if.sv - APB slave FSM with programmable wait states and address decode
module timer_apb_if
  import timer_pkg::*;
#(
  parameter int WAIT = 0
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  output logic       pready,
  output logic       wr_en,
  output logic       rd_en,
  output logic       addr_hit
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  apb_state_e state_q, state_nxt;
  logic [3:0] wait_q, wait_nxt;
  logic       setup_req;

  assign setup_req = psel && !penable;
  assign pready    = (state_q == ST_ACCESS) && (wait_q == WAIT_CNT);
  assign wr_en     = psel && penable && pready && pwrite;
  assign rd_en     = psel && penable && pready && !pwrite;
  assign addr_hit  = (paddr == ADDR_TIER) || (paddr == ADDR_TISR) ||
                     (paddr == ADDR_OVCNT) || (paddr == ADDR_IPEND);

  // State and wait counter registers; reset aborts any transfer in flight
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= ST_IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_nxt;
      wait_q  <= wait_nxt;
    end
  end

  // Next-state: SETUP always lasts one cycle, ACCESS holds until the wait count is reached
  always_comb begin
    state_nxt = state_q;
    wait_nxt  = wait_q;
    case (state_q)
      ST_IDLE: begin
        wait_nxt = 4'd0;
        if (setup_req) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        wait_nxt  = 4'd0;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (wait_q == WAIT_CNT) begin
          wait_nxt  = 4'd0;
          state_nxt = setup_req ? ST_SETUP : ST_IDLE;
        end else begin
          wait_nxt = wait_q + 4'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        wait_nxt  = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - timer overflow/underflow status latch, event counter and interrupt line
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter int WAIT = 0
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  input  logic       ovf_pulse,
  input  logic       udf_pulse,
  output logic       irq
);

  logic       wr_en, rd_en, addr_hit;
  logic       wr_tier, wr_tisr, wr_ovcnt;
  logic [1:0] tier_q, tier_nxt;
  logic [1:0] tisr_q, tisr_nxt;
  logic [1:0] pulse_set, w1c_mask;
  logic [7:0] ovcnt_q, ovcnt_nxt;
  logic [7:0] rd_mux;
  logic       unused_pwdata;

  timer_apb_if #(.WAIT(WAIT)) u_apb_if (
    .pclk     (pclk),
    .preset_n (preset_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pready   (pready),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr_hit (addr_hit)
  );

  assign wr_tier       = wr_en && (paddr == ADDR_TIER);
  assign wr_tisr       = wr_en && (paddr == ADDR_TISR);
  assign wr_ovcnt      = wr_en && (paddr == ADDR_OVCNT);
  assign unused_pwdata = ^pwdata[7:2];

  // Next register values: pulses win over a same-cycle W1C, counter saturates at 0xFF
  always_comb begin
    pulse_set          = 2'b00;
    pulse_set[OVF_BIT] = ovf_pulse;
    pulse_set[UDF_BIT] = udf_pulse;
    w1c_mask           = wr_tisr ? pwdata[1:0] : 2'b00;
    tier_nxt           = wr_tier ? pwdata[1:0] : tier_q;
    tisr_nxt           = (tisr_q & ~w1c_mask) | pulse_set;
    ovcnt_nxt          = ovcnt_q;
    if (wr_ovcnt) begin
      ovcnt_nxt = ovf_pulse ? 8'h01 : 8'h00;
    end else if (ovf_pulse && (ovcnt_q != 8'hFF)) begin
      ovcnt_nxt = ovcnt_q + 8'h01;
    end
  end

  // Register file and irq; irq looks at next-state values so it follows the cause by one cycle
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      tier_q  <= 2'b00;
      tisr_q  <= 2'b00;
      ovcnt_q <= 8'h00;
      irq     <= 1'b0;
    end else begin
      tier_q  <= tier_nxt;
      tisr_q  <= tisr_nxt;
      ovcnt_q <= ovcnt_nxt;
      irq     <= |(tier_nxt & tisr_nxt);
    end
  end

  // Read mux; unmapped addresses read as zero and the bus is quiet outside a read completion
  always_comb begin
    rd_mux = 8'h00;
    case (paddr)
      ADDR_TIER:  rd_mux = {6'd0, tier_q};
      ADDR_TISR:  rd_mux = {6'd0, tisr_q};
      ADDR_OVCNT: rd_mux = ovcnt_q;
      ADDR_IPEND: rd_mux = {6'd0, tier_q & tisr_q};
      default:    rd_mux = 8'h00;
    endcase
  end

  assign prdata  = rd_en ? rd_mux : 8'h00;
  assign pslverr = pready && !addr_hit;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb/tb_timer_irq_ctrl.sv - self-checking bench for timer_irq_ctrl with a read scoreboard
module tb_timer_irq_ctrl;

  localparam int WAIT_TB = 3;
  localparam int EXP_CYC = 2 + WAIT_TB;

  logic       pclk;
  logic       preset_n;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;
  logic       ovf_pulse, udf_pulse;
  logic       irq;

  int errors = 0;
  int checks = 0;

  logic [1:0] m_tier, m_tisr;
  logic [7:0] m_ovcnt;

  typedef struct {
    logic [7:0] data;
    logic       err;
    string      name;
  } exp_t;
  exp_t sb_q[$];

  timer_irq_ctrl #(.WAIT(WAIT_TB)) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .ovf_pulse (ovf_pulse),
    .udf_pulse (udf_pulse),
    .irq       (irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic exp_irq();
    return |(m_tier & m_tisr);
  endfunction

  task automatic model_reset();
    m_tier  = 2'b00;
    m_tisr  = 2'b00;
    m_ovcnt = 8'h00;
  endtask

  task automatic model_event(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                             input logic ovf, input logic udf);
    logic ovcnt_cleared;
    ovcnt_cleared = 1'b0;
    if (wr) begin
      if (addr == 8'h10) m_tier = wdata[1:0];
      if (addr == 8'h11) m_tisr = m_tisr & ~wdata[1:0];
      if (addr == 8'h12) begin
        m_ovcnt       = 8'h00;
        ovcnt_cleared = 1'b1;
      end
    end
    if (udf) m_tisr[1] = 1'b1;
    if (ovf) begin
      m_tisr[0] = 1'b1;
      if (ovcnt_cleared) m_ovcnt = 8'h01;
      else if (m_ovcnt != 8'hFF) m_ovcnt = m_ovcnt + 8'h01;
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] addr);
    case (addr)
      8'h10:   return {6'd0, m_tier};
      8'h11:   return {6'd0, m_tisr};
      8'h12:   return m_ovcnt;
      8'h13:   return {6'd0, m_tier & m_tisr};
      default: return 8'h00;
    endcase
  endfunction

  // One APB transfer; optional pulses are driven on the completion cycle
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic c_ovf, input logic c_udf,
                          output logic [7:0] rdata, output logic rerr);
    int   cyc;
    logic done;
    rdata   = 8'hxx;
    rerr    = 1'bx;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    tick();
    penable = 1'b1;
    cyc     = 0;
    done    = 1'b0;
    while (!done && cyc < 40) begin
      cyc++;
      if (pready === 1'b1) begin
        rdata     = prdata;
        rerr      = pslverr;
        done      = 1'b1;
        ovf_pulse = c_ovf;
        udf_pulse = c_udf;
      end
      tick();
    end
    ovf_pulse = 1'b0;
    udf_pulse = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    checks++;
    if (!done || cyc != EXP_CYC) begin
      errors++;
      $display("FAIL latency addr=%02h: got %0d cycles (done=%0b), expected %0d", addr, cyc, done, EXP_CYC);
    end
    if (done) model_event(wr, addr, wdata, c_ovf, c_udf);
  endtask

  task automatic apb_read(input logic [7:0] addr, input string name);
    exp_t       e, got_e;
    logic [7:0] rd;
    logic       er;
    e.data = model_read(addr);
    e.err  = !(addr >= 8'h10 && addr <= 8'h13);
    e.name = name;
    sb_q.push_back(e);
    apb_xfer(1'b0, addr, 8'h00, 1'b0, 1'b0, rd, er);
    got_e = sb_q.pop_front();
    checks++;
    if (rd !== got_e.data || er !== got_e.err) begin
      errors++;
      $display("FAIL %s: prdata=%02h pslverr=%b, expected prdata=%02h pslverr=%b",
               got_e.name, rd, er, got_e.data, got_e.err);
    end
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [7:0] wdata,
                           input logic c_ovf, input logic c_udf);
    logic [7:0] rd;
    logic       er;
    logic       exp_err;
    exp_err = !(addr >= 8'h10 && addr <= 8'h13);
    apb_xfer(1'b1, addr, wdata, c_ovf, c_udf, rd, er);
    checks++;
    if (er !== exp_err) begin
      errors++;
      $display("FAIL write_err addr=%02h: pslverr=%b, expected %b", addr, er, exp_err);
    end
  endtask

  task automatic pulse(input logic ovf, input logic udf);
    ovf_pulse = ovf;
    udf_pulse = udf;
    tick();
    ovf_pulse = 1'b0;
    udf_pulse = 1'b0;
    model_event(1'b0, 8'h00, 8'h00, ovf, udf);
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    model_reset();
    repeat (3) tick();
    checks++;
    if (irq !== 1'b0 || pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: irq=%b pready=%b pslverr=%b prdata=%02h, expected 0/0/0/00",
               irq, pready, pslverr, prdata);
    end
    preset_n = 1'b1;
    tick();
    apb_read(8'h10, "reset_tier");
    apb_read(8'h11, "reset_tisr");
    apb_read(8'h12, "reset_ovcnt");
    apb_read(8'h13, "reset_ipend");
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: irq=%b, expected 0", irq);
    end
  endtask

  task automatic test_overflow();
    apb_write(8'h10, 8'h01, 1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    checks++;
    if (irq !== exp_irq() || irq !== 1'b1) begin
      errors++;
      $display("FAIL ovf_irq: irq=%b, expected 1", irq);
    end
    apb_read(8'h11, "ovf_tisr");
    apb_read(8'h12, "ovf_ovcnt");
    apb_write(8'h11, 8'h01, 1'b0, 1'b0);
    checks++;
    if (irq !== exp_irq() || irq !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear_irq: irq=%b, expected 0", irq);
    end
    apb_read(8'h11, "ovf_tisr_cleared");
  endtask

  task automatic test_mask_collision();
    apb_write(8'h10, 8'h00, 1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    repeat (2) begin
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL mask_irq: irq=%b, expected 0", irq);
      end
      tick();
    end
    apb_read(8'h11, "mask_tisr");
    apb_write(8'h10, 8'h02, 1'b0, 1'b0);
    checks++;
    if (irq !== exp_irq() || irq !== 1'b1) begin
      errors++;
      $display("FAIL unmask_irq: irq=%b, expected 1", irq);
    end
    apb_read(8'h13, "unmask_ipend");
    apb_write(8'h11, 8'h02, 1'b0, 1'b1);
    apb_read(8'h11, "collision_tisr");
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL collision_irq: irq=%b, expected 1", irq);
    end
  endtask

  task automatic test_saturation();
    apb_write(8'h12, 8'h5A, 1'b0, 1'b0);
    apb_read(8'h12, "ovcnt_cleared");
    for (int i = 0; i < 300; i++) pulse(1'b1, 1'b0);
    apb_read(8'h12, "ovcnt_saturated");
    apb_write(8'h12, 8'h00, 1'b1, 1'b0);
    apb_read(8'h12, "ovcnt_clear_with_pulse");
  endtask

  task automatic test_error_and_width();
    apb_read(8'h20, "unmapped_read");
    apb_write(8'h20, 8'hFF, 1'b0, 1'b0);
    apb_read(8'h10, "tier_after_unmapped_write");
    apb_write(8'h10, 8'hFF, 1'b0, 1'b0);
    apb_read(8'h10, "tier_upper_bits_zero");
    apb_read(8'h0F, "unmapped_below");
    apb_read(8'h13, "ipend_both");
  endtask

  task automatic test_reset_mid();
    apb_write(8'h11, 8'h03, 1'b0, 1'b0);
    apb_write(8'h10, 8'h01, 1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_irq: irq=%b, expected 1", irq);
    end
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h10;
    pwdata  = 8'h03;
    tick();
    penable = 1'b1;
    repeat (2) tick();
    preset_n = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0 || pready !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: irq=%b pready=%b, expected 0/0", irq, pready);
    end
    ovf_pulse = 1'b1;
    udf_pulse = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (irq !== 1'b0 || pready !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL reset_hold cycle %0d: irq=%b pready=%b, expected 0/0", i, irq, pready);
      end
    end
    ovf_pulse = 1'b0;
    udf_pulse = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    model_reset();
    preset_n  = 1'b1;
    tick();
    apb_read(8'h10, "post_reset_tier");
    apb_read(8'h11, "post_reset_tisr");
    apb_read(8'h12, "post_reset_ovcnt");
    apb_read(8'h13, "post_reset_ipend");
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_irq: irq=%b, expected 0", irq);
    end
  endtask

  initial begin
    preset_n  = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = 8'h00;
    pwdata    = 8'h00;
    ovf_pulse = 1'b0;
    udf_pulse = 1'b0;
    test_reset();
    test_overflow();
    test_mask_collision();
    test_saturation();
    test_error_and_width();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
